// File: rtl/add_seq_pkg.sv
// Shared constants and FSM encoding for the nibble-serial add/sub sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package add_seq_pkg;

  localparam int DATA_W  = 16;
  localparam int SLICE_W = 4;
  localparam int NIBBLES = DATA_W / SLICE_W;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_16b_if.sv
// Operation request / result bundle between the issuing control FSM and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: requester must hold off while o_busy is high; starts seen while busy are dropped.
interface add_seq_16b_if;
  import add_seq_pkg::*;

  logic              i_start;
  logic              i_sub;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              i_cin;
  logic              i_abort;
  logic [DATA_W-1:0] o_s;
  logic              o_cy;
  logic              o_ovf;
  logic              o_busy;
  logic              o_done;

  // Requester side: drives the op, observes the result.
  modport master (
    output i_start, i_sub, i_a, i_b, i_cin, i_abort,
    input  o_s, o_cy, o_ovf, o_busy, o_done
  );

  // Sequencer side.
  modport slave (
    input  i_start, i_sub, i_a, i_b, i_cin, i_abort,
    output o_s, o_cy, o_ovf, o_busy, o_done
  );

endinterface

// File: rtl/rca_4b.sv
// 4-bit ripple-carry adder slice shared by the serial sequencer.
// Latency: combinational.
// Backpressure: none.
module rca_4b (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);

  logic [4:0] w_c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/add_seq_16b.sv
// Nibble-serial 16-bit add/subtract using one shared rca_4b slice and a registered carry.
// Latency: 4 cycles from accept edge to o_done; one op per 5 cycles (back-to-back start from DONE).
// Backpressure: o_busy high during RUN; i_start while busy is dropped, no queueing.
module add_seq_16b
  import add_seq_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  add_seq_16b_if.slave       bus
);

  localparam int ACC_W = DATA_W - SLICE_W;

  // The datapath is hard-wired around a 4-bit slice; any other geometry is unbuildable.
  if (SLICE_W != 4 || (DATA_W % SLICE_W) != 0) begin : g_bad_cfg
    $error("add_seq_16b: SLICE_W must be 4 and divide DATA_W");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;      // already inverted for subtract
  logic               r_carry;
  logic [ACC_W-1:0]   r_acc;    // lower nibbles collected so far, newest at the top
  logic [DATA_W-1:0]  r_s;
  logic               r_cy;
  logic               r_ovf;
  logic               r_done;

  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_last;
  logic               w_c_into_msb;

  // Nibble select follows the counter; nibble 0 is processed first.
  assign w_a_nib = r_a[r_cnt*SLICE_W +: SLICE_W];
  assign w_b_nib = r_b[r_cnt*SLICE_W +: SLICE_W];
  assign w_last  = (r_cnt == CNT_W'(NIBBLES - 1));

  rca_4b u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  // The slice only exposes carry out of bit 15; recover carry into bit 15 from the sum bit.
  assign w_c_into_msb = r_a[DATA_W-1] ^ r_b[DATA_W-1] ^ w_sum[SLICE_W-1];

  // Control FSM plus operand/accumulator/result registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cy    <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // Abort has no meaning outside RUN, so a simultaneous start simply wins.
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b ^ {DATA_W{bus.i_sub}};
            r_carry <= bus.i_sub | bus.i_cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (bus.i_abort) begin
            // Drop the partial result; published outputs stay as they were.
            r_state <= IDLE;
          end else begin
            r_acc   <= {w_sum, r_acc[ACC_W-1:SLICE_W]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_s     <= {w_sum, r_acc};
              r_cy    <= w_cout;
              r_ovf   <= w_c_into_msb ^ w_cout;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_s    = r_s;
  assign bus.o_cy   = r_cy;
  assign bus.o_ovf  = r_ovf;
  assign bus.o_busy = (r_state == RUN);
  assign bus.o_done = r_done;

endmodule

// File: tb/tb_add_seq_16b.sv
// Directed self-checking bench for add_seq_16b.
module tb_add_seq_16b;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  add_seq_16b_if u_if ();

  add_seq_16b dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an op for exactly one edge (the accept edge E0).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    u_if.i_a     = a;
    u_if.i_b     = b;
    u_if.i_cin   = cin;
    u_if.i_sub   = sub;
    u_if.i_start = 1'b1;
    tick();
    u_if.i_start = 1'b0;
  endtask

  // Bounded wait for o_done; reports edges consumed and whether it arrived.
  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (u_if.o_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (u_if.o_s !== 16'h0000) begin errors++; $display("FAIL reset o_s: got %h want %h", u_if.o_s, 16'h0000); end
    checks++; if (u_if.o_cy !== 1'b0) begin errors++; $display("FAIL reset o_cy: got %b want 0", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b0) begin errors++; $display("FAIL reset o_ovf: got %b want 0", u_if.o_ovf); end
    checks++; if (u_if.o_busy !== 1'b0) begin errors++; $display("FAIL reset o_busy: got %b want 0", u_if.o_busy); end
    checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL reset o_done: got %b want 0", u_if.o_done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_basic;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (u_if.o_busy !== 1'b1) begin errors++; $display("FAIL basic busy c%0d: got %b want 1", k + 1, u_if.o_busy); end
      checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL basic early done c%0d: got %b want 0", k + 1, u_if.o_done); end
      tick();
    end
    checks++; if (u_if.o_done !== 1'b1) begin errors++; $display("FAIL basic done c5: got %b want 1", u_if.o_done); end
    checks++; if (u_if.o_busy !== 1'b0) begin errors++; $display("FAIL basic busy c5: got %b want 0", u_if.o_busy); end
    checks++; if (u_if.o_s !== 16'h5555) begin errors++; $display("FAIL basic o_s: got %h want %h", u_if.o_s, 16'h5555); end
    checks++; if (u_if.o_cy !== 1'b0) begin errors++; $display("FAIL basic o_cy: got %b want 0", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b0) begin errors++; $display("FAIL basic o_ovf: got %b want 0", u_if.o_ovf); end
    tick();
    checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL basic done pulse width: got %b want 0", u_if.o_done); end
  endtask

  task automatic test_add_carry;
    int cyc;
    bit seen;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(8, cyc, seen);
    checks++; if (!seen || cyc != 4) begin errors++; $display("FAIL wrap latency: got %0d seen %b want 4", cyc, seen); end
    checks++; if (u_if.o_s !== 16'h0000) begin errors++; $display("FAIL wrap o_s: got %h want %h", u_if.o_s, 16'h0000); end
    checks++; if (u_if.o_cy !== 1'b1) begin errors++; $display("FAIL wrap o_cy: got %b want 1", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b0) begin errors++; $display("FAIL wrap o_ovf: got %b want 0", u_if.o_ovf); end
    tick();
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(8, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ovf_add done: got none want pulse"); end
    checks++; if (u_if.o_s !== 16'h8000) begin errors++; $display("FAIL ovf_add o_s: got %h want %h", u_if.o_s, 16'h8000); end
    checks++; if (u_if.o_cy !== 1'b0) begin errors++; $display("FAIL ovf_add o_cy: got %b want 0", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_add o_ovf: got %b want 1", u_if.o_ovf); end
    tick();
  endtask

  task automatic test_sub;
    int cyc;
    bit seen;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(8, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL sub_neg done: got none want pulse"); end
    checks++; if (u_if.o_s !== 16'hFFFE) begin errors++; $display("FAIL sub_neg o_s: got %h want %h", u_if.o_s, 16'hFFFE); end
    checks++; if (u_if.o_cy !== 1'b0) begin errors++; $display("FAIL sub_neg o_cy: got %b want 0", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b0) begin errors++; $display("FAIL sub_neg o_ovf: got %b want 0", u_if.o_ovf); end
    tick();
    // i_cin=1 here must be ignored in subtract mode.
    start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_done(8, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL sub_ovf done: got none want pulse"); end
    checks++; if (u_if.o_s !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf o_s: got %h want %h", u_if.o_s, 16'h7FFF); end
    checks++; if (u_if.o_cy !== 1'b1) begin errors++; $display("FAIL sub_ovf o_cy: got %b want 1", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf o_ovf: got %b want 1", u_if.o_ovf); end
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit seen;
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    tick();
    // RUN cycle 2: a start with different operands must be dropped.
    u_if.i_a     = 16'hFFFF;
    u_if.i_b     = 16'hFFFF;
    u_if.i_sub   = 1'b1;
    u_if.i_start = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    u_if.i_sub   = 1'b0;
    wait_done(8, cyc, seen);
    checks++; if (!seen || cyc != 2) begin errors++; $display("FAIL ignore latency: got %0d seen %b want 2", cyc, seen); end
    checks++; if (u_if.o_s !== 16'h1000) begin errors++; $display("FAIL ignore o_s: got %h want %h", u_if.o_s, 16'h1000); end
    // Start again in the DONE cycle.
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    checks++; if (u_if.o_busy !== 1'b1) begin errors++; $display("FAIL b2b busy: got %b want 1", u_if.o_busy); end
    wait_done(8, cyc, seen);
    checks++; if (!seen || (cyc + 1) != 5) begin errors++; $display("FAIL b2b spacing: got %0d seen %b want 5", cyc + 1, seen); end
    checks++; if (u_if.o_s !== 16'h0003) begin errors++; $display("FAIL b2b o_s: got %h want %h", u_if.o_s, 16'h0003); end
    tick();
  endtask

  task automatic test_abort;
    int cyc;
    int pulses;
    bit seen;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(8, cyc, seen);
    checks++; if (!seen || u_if.o_s !== 16'h5555) begin errors++; $display("FAIL abort pre o_s: got %h seen %b want %h", u_if.o_s, seen, 16'h5555); end
    tick();
    start_op(16'h1111, 16'h1111, 1'b0, 1'b0);
    tick();
    u_if.i_abort = 1'b1;
    tick();
    u_if.i_abort = 1'b0;
    checks++; if (u_if.o_busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", u_if.o_busy); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (u_if.o_done === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort done pulses: got %0d want 0", pulses); end
    checks++; if (u_if.o_s !== 16'h5555) begin errors++; $display("FAIL abort o_s held: got %h want %h", u_if.o_s, 16'h5555); end
    // Abort alongside a start in IDLE: start is accepted.
    u_if.i_abort = 1'b1;
    start_op(16'h0002, 16'h0003, 1'b1, 1'b0);
    u_if.i_abort = 1'b0;
    checks++; if (u_if.o_busy !== 1'b1) begin errors++; $display("FAIL abort+start busy: got %b want 1", u_if.o_busy); end
    wait_done(8, cyc, seen);
    checks++; if (!seen || u_if.o_s !== 16'h0006) begin errors++; $display("FAIL abort+start o_s: got %h seen %b want %h", u_if.o_s, seen, 16'h0006); end
    tick();
  endtask

  task automatic test_reset_mid_op;
    int cyc;
    bit seen;
    start_op(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (u_if.o_s !== 16'h0000) begin errors++; $display("FAIL midrst o_s: got %h want %h", u_if.o_s, 16'h0000); end
    checks++; if (u_if.o_cy !== 1'b0) begin errors++; $display("FAIL midrst o_cy: got %b want 0", u_if.o_cy); end
    checks++; if (u_if.o_ovf !== 1'b0) begin errors++; $display("FAIL midrst o_ovf: got %b want 0", u_if.o_ovf); end
    checks++; if (u_if.o_busy !== 1'b0) begin errors++; $display("FAIL midrst o_busy: got %b want 0", u_if.o_busy); end
    checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL midrst o_done: got %b want 0", u_if.o_done); end
    rst_n = 1'b1;
    start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done(8, cyc, seen);
    checks++; if (!seen || cyc != 4) begin errors++; $display("FAIL postrst latency: got %0d seen %b want 4", cyc, seen); end
    checks++; if (u_if.o_s !== 16'h5556) begin errors++; $display("FAIL postrst o_s: got %h want %h", u_if.o_s, 16'h5556); end
    tick();
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    u_if.i_start = 1'b0;
    u_if.i_sub   = 1'b0;
    u_if.i_a     = '0;
    u_if.i_b     = '0;
    u_if.i_cin   = 1'b0;
    u_if.i_abort = 1'b0;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
